// File: rtl/timer_ctrl_master_if.sv
// Avalon-MM bundle between timer_ctrl_master and the interval-timer s1 port.
interface timer_ctrl_master_if;
   logic [2:0]  tmr_address;
   logic        tmr_chipselect;
   logic        tmr_write_n;
   logic [15:0] tmr_writedata;
   logic [15:0] tmr_readdata;
   logic        tmr_irq;

   modport master (
      output tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
      input  tmr_readdata, tmr_irq
   );

   modport slave (
      input  tmr_address, tmr_chipselect, tmr_write_n, tmr_writedata,
      output tmr_readdata, tmr_irq
   );
endinterface

// File: rtl/timer_ctrl_master.sv
// CPU-less Avalon-MM master for the interval timer: programs the period, services
// every timeout IRQ, counts ticks and performs on-demand 32-bit snapshot reads.
module timer_ctrl_master #(
   parameter int unsigned TICK_W    = 32,
   parameter logic [3:0]  CTRL_RUN  = 4'h7,
   parameter logic [3:0]  CTRL_HALT = 4'h8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               cfg_start,
   input  logic               cfg_stop,
   input  logic [31:0]        period_in,
   input  logic               snap_req,
   output logic               snap_valid,
   output logic [31:0]        snap_value,
   output logic [TICK_W-1:0]  tick_count,
   output logic               tick_pulse,
   output logic               running,
   output logic               busy,
   timer_ctrl_master_if.master tmr
);

   localparam logic [2:0] A_STATUS = 3'd0;
   localparam logic [2:0] A_CTRL   = 3'd1;
   localparam logic [2:0] A_PER_L  = 3'd2;
   localparam logic [2:0] A_PER_H  = 3'd3;
   localparam logic [2:0] A_SNAP_L = 3'd4;
   localparam logic [2:0] A_SNAP_H = 3'd5;

   typedef enum logic [3:0] {
      S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTRL, S_RUN, S_CLR, S_CLR_WAIT,
      S_SNAP_WR, S_SNAP_RL, S_SNAP_RH, S_SNAP_DONE, S_HALT_CTRL, S_HALT_CLR
   } state_t;

   state_t      r_state;
   logic [15:0] r_period_hi;
   logic [15:0] r_snap_lo;

   // Bus outputs are issued on the edge that enters a state, so each state's
   // transfer is on the bus for exactly the cycle that state is occupied.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state             <= S_IDLE;
         r_period_hi         <= '0;
         r_snap_lo           <= '0;
         snap_value          <= '0;
         snap_valid          <= 1'b0;
         tick_count          <= '0;
         tick_pulse          <= 1'b0;
         running             <= 1'b0;
         busy                <= 1'b0;
         tmr.tmr_address     <= '0;
         tmr.tmr_chipselect  <= 1'b0;
         tmr.tmr_write_n     <= 1'b1;
         tmr.tmr_writedata   <= '0;
      end else begin
         tmr.tmr_address     <= '0;
         tmr.tmr_chipselect  <= 1'b0;
         tmr.tmr_write_n     <= 1'b1;
         tmr.tmr_writedata   <= '0;
         tick_pulse          <= 1'b0;
         snap_valid          <= 1'b0;

         unique case (r_state)
            S_IDLE: begin
               if (cfg_start) begin
                  r_period_hi        <= period_in[31:16];
                  tmr.tmr_chipselect <= 1'b1;
                  tmr.tmr_write_n    <= 1'b0;
                  tmr.tmr_address    <= A_PER_L;
                  tmr.tmr_writedata  <= period_in[15:0];
                  busy               <= 1'b1;
                  r_state            <= S_WR_PL;
               end
            end
            S_WR_PL: begin
               tmr.tmr_chipselect <= 1'b1;
               tmr.tmr_write_n    <= 1'b0;
               tmr.tmr_address    <= A_PER_H;
               tmr.tmr_writedata  <= r_period_hi;
               r_state            <= S_WR_PH;
            end
            S_WR_PH: begin
               tmr.tmr_chipselect <= 1'b1;
               tmr.tmr_write_n    <= 1'b0;
               tmr.tmr_address    <= A_CTRL;
               tmr.tmr_writedata  <= 16'(CTRL_RUN);
               r_state            <= S_WR_CTRL;
            end
            S_WR_CTRL: begin
               busy    <= 1'b0;
               running <= 1'b1;
               r_state <= S_RUN;
            end
            // Priority irq > stop > snap; losing requests are dropped.
            S_RUN: begin
               if (tmr.tmr_irq) begin
                  tmr.tmr_chipselect <= 1'b1;
                  tmr.tmr_write_n    <= 1'b0;
                  tmr.tmr_address    <= A_STATUS;
                  tick_count         <= tick_count + TICK_W'(1);
                  tick_pulse         <= 1'b1;
                  busy               <= 1'b1;
                  r_state            <= S_CLR;
               end else if (cfg_stop) begin
                  tmr.tmr_chipselect <= 1'b1;
                  tmr.tmr_write_n    <= 1'b0;
                  tmr.tmr_address    <= A_CTRL;
                  tmr.tmr_writedata  <= 16'(CTRL_HALT);
                  busy               <= 1'b1;
                  running            <= 1'b0;
                  r_state            <= S_HALT_CTRL;
               end else if (snap_req) begin
                  tmr.tmr_chipselect <= 1'b1;
                  tmr.tmr_write_n    <= 1'b0;
                  tmr.tmr_address    <= A_SNAP_L;
                  busy               <= 1'b1;
                  r_state            <= S_SNAP_WR;
               end
            end
            // irq is still high from the slave here; it is deliberately ignored.
            S_CLR: begin
               r_state <= S_CLR_WAIT;
            end
            S_CLR_WAIT: begin
               busy    <= 1'b0;
               r_state <= S_RUN;
            end
            S_SNAP_WR: begin
               tmr.tmr_chipselect <= 1'b1;
               tmr.tmr_address    <= A_SNAP_L;
               r_state            <= S_SNAP_RL;
            end
            S_SNAP_RL: begin
               tmr.tmr_chipselect <= 1'b1;
               tmr.tmr_address    <= A_SNAP_H;
               r_state            <= S_SNAP_RH;
            end
            S_SNAP_RH: begin
               r_snap_lo <= tmr.tmr_readdata;
               r_state   <= S_SNAP_DONE;
            end
            S_SNAP_DONE: begin
               snap_value <= {tmr.tmr_readdata, r_snap_lo};
               snap_valid <= 1'b1;
               busy       <= 1'b0;
               r_state    <= S_RUN;
            end
            S_HALT_CTRL: begin
               tmr.tmr_chipselect <= 1'b1;
               tmr.tmr_write_n    <= 1'b0;
               tmr.tmr_address    <= A_STATUS;
               r_state            <= S_HALT_CLR;
            end
            S_HALT_CLR: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               running <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Scoreboard bench for timer_ctrl_master with a small interval-timer slave model.
module tb_timer_ctrl_master;
   localparam int unsigned TICK_W = 4;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              cfg_start = 1'b0;
   logic              cfg_stop = 1'b0;
   logic [31:0]       period_in = '0;
   logic              snap_req = 1'b0;
   logic              snap_valid;
   logic [31:0]       snap_value;
   logic [TICK_W-1:0] tick_count;
   logic              tick_pulse;
   logic              running;
   logic              busy;

   timer_ctrl_master_if bus();

   timer_ctrl_master #(.TICK_W(TICK_W), .CTRL_RUN(4'h7), .CTRL_HALT(4'h8)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_stop(cfg_stop),
      .period_in(period_in), .snap_req(snap_req), .snap_valid(snap_valid),
      .snap_value(snap_value), .tick_count(tick_count), .tick_pulse(tick_pulse),
      .running(running), .busy(busy), .tmr(bus)
   );

   always #5 clk = ~clk;

   // Slave model: timeout flag set by stimulus, cleared by a status write; irq lags
   // the flag by one register stage; readdata is registered.
   logic        fire = 1'b0;
   logic        m_to = 1'b0;
   logic        m_irq = 1'b0;
   logic [15:0] m_rd = '0;
   logic [31:0] m_cnt = '0;
   logic [31:0] m_snap = '0;

   always @(posedge clk) begin
      if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd4) m_snap <= m_cnt;
      if (bus.tmr_chipselect && bus.tmr_write_n)
         m_rd <= (bus.tmr_address == 3'd4) ? m_snap[15:0] :
                 (bus.tmr_address == 3'd5) ? m_snap[31:16] : 16'h0;
      if (fire) m_to <= 1'b1;
      else if (bus.tmr_chipselect && !bus.tmr_write_n && bus.tmr_address == 3'd0) m_to <= 1'b0;
      m_irq <= m_to;
   end
   assign bus.tmr_readdata = m_rd;
   assign bus.tmr_irq      = m_irq;

   int n_vec = 0;
   int n_err = 0;
   logic [19:0]       q_bus[$];
   logic [TICK_W-1:0] q_tick[$];
   logic [31:0]       q_snap[$];
   logic [TICK_W-1:0] exp_tick = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every bus transfer, tick pulse and snapshot is popped against the scoreboard.
   always @(negedge clk) begin
      logic [19:0] e;
      if (bus.tmr_chipselect === 1'b1) begin
         if (q_bus.size() == 0) chk("bus_unexpected", {bus.tmr_address, bus.tmr_write_n, bus.tmr_writedata}, 20'hFFFFF);
         else begin
            e = q_bus.pop_front();
            chk("bus_xfer", {bus.tmr_address, bus.tmr_write_n, bus.tmr_writedata}, e);
         end
      end
      if (tick_pulse === 1'b1) begin
         if (q_tick.size() == 0) chk("tick_unexpected", 64'(tick_count), 64'hDEAD);
         else chk("tick_count", 64'(tick_count), 64'(q_tick.pop_front()));
      end
      if (snap_valid === 1'b1) begin
         if (q_snap.size() == 0) chk("snap_unexpected", 64'(snap_value), 64'hDEAD);
         else chk("snap_value", 64'(snap_value), 64'(q_snap.pop_front()));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cyc(2);
      reset_n = 1'b1;
      exp_tick = '0;
   endtask

   task automatic push_start(input logic [31:0] p);
      q_bus.push_back({3'd2, 1'b0, p[15:0]});
      q_bus.push_back({3'd3, 1'b0, p[31:16]});
      q_bus.push_back({3'd1, 1'b0, 16'h0007});
   endtask

   task automatic do_start(input logic [31:0] p, input bit check_timing);
      push_start(p);
      period_in = p;
      cfg_start = 1'b1;
      cyc(1);
      cfg_start = 1'b0;
      period_in = '0;
      for (int i = 0; i < 3; i++) begin
         if (check_timing) begin
            chk("start_busy", 64'(busy), 64'd1);
            chk("start_running", 64'(running), 64'd0);
         end
         cyc(1);
      end
      chk("run_running", 64'(running), 64'd1);
      chk("run_busy", 64'(busy), 64'd0);
   endtask

   task automatic do_irq();
      q_bus.push_back({3'd0, 1'b0, 16'h0000});
      exp_tick = exp_tick + TICK_W'(1);
      q_tick.push_back(exp_tick);
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
      cyc(6);
   endtask

   initial begin
      // Reset state
      reset_n = 1'b0;
      cyc(2);
      chk("rst_cs", 64'(bus.tmr_chipselect), 64'd0);
      chk("rst_write_n", 64'(bus.tmr_write_n), 64'd1);
      chk("rst_addr", 64'(bus.tmr_address), 64'd0);
      chk("rst_wdata", 64'(bus.tmr_writedata), 64'd0);
      chk("rst_snap", {31'd0, snap_valid, snap_value}, 64'd0);
      chk("rst_tick", {tick_pulse, tick_count}, 64'd0);
      chk("rst_run_busy", {running, busy}, 64'd0);
      reset_n = 1'b1;
      cyc(1);

      // Start sequence
      do_start(32'h0001_0005, 1'b1);

      // Three timeouts, one tick each despite the irq lag
      for (int i = 0; i < 3; i++) do_irq();
      chk("tick_after_3", 64'(tick_count), 64'd3);

      // Snapshot with latency check
      m_cnt = 32'h0012_3456;
      q_bus.push_back({3'd4, 1'b0, 16'h0000});
      q_bus.push_back({3'd4, 1'b1, 16'h0000});
      q_bus.push_back({3'd5, 1'b1, 16'h0000});
      q_snap.push_back(32'h0012_3456);
      snap_req = 1'b1;
      cyc(1);
      snap_req = 1'b0;
      cyc(3);
      chk("snap_early", 64'(snap_valid), 64'd0);
      cyc(1);
      chk("snap_latency", 64'(snap_valid), 64'd1);
      cyc(2);

      // irq + stop + snap in one RUN cycle: only the clear is taken
      q_bus.push_back({3'd0, 1'b0, 16'h0000});
      exp_tick = exp_tick + TICK_W'(1);
      q_tick.push_back(exp_tick);
      fire = 1'b1;
      cyc(1);
      fire = 1'b0;
      cyc(1);
      cfg_stop = 1'b1;
      snap_req = 1'b1;
      cyc(1);
      cfg_stop = 1'b0;
      snap_req = 1'b0;
      cyc(5);
      chk("prio_tick", 64'(tick_count), 64'd4);
      chk("prio_running", 64'(running), 64'd1);

      // Halt sequence
      q_bus.push_back({3'd1, 1'b0, 16'h0008});
      q_bus.push_back({3'd0, 1'b0, 16'h0000});
      cfg_stop = 1'b1;
      cyc(1);
      cfg_stop = 1'b0;
      cyc(2);
      chk("halt_idle", {running, busy}, 64'd0);
      chk("halt_tick", 64'(tick_count), 64'd4);
      cyc(1);

      // Wrap of a 4-bit tick counter after 16 timeouts
      do_reset();
      do_start(32'h0000_0009, 1'b0);
      for (int i = 0; i < 16; i++) do_irq();
      chk("tick_wrap", 64'(tick_count), 64'd0);

      // Reset during WR_PH aborts; restart replays all three writes
      do_reset();
      q_bus.push_back({3'd2, 1'b0, 16'h5678});
      q_bus.push_back({3'd3, 1'b0, 16'h1234});
      period_in = 32'h1234_5678;
      cfg_start = 1'b1;
      cyc(1);
      cfg_start = 1'b0;
      cyc(1);
      reset_n = 1'b0;
      cyc(1);
      reset_n = 1'b1;
      chk("abort_cs", 64'(bus.tmr_chipselect), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_tick", 64'(tick_count), 64'd0);
      cyc(1);
      do_start(32'h1234_5678, 1'b1);
      cyc(3);

      chk("bus_q_empty", 64'(q_bus.size()), 64'd0);
      chk("tick_q_empty", 64'(q_tick.size()), 64'd0);
      chk("snap_q_empty", 64'(q_snap.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
